// File: rtl/fb_pkg.sv
// Shared constants, pixel type and FSM encoding for the framebuffer swap controller.
package fb_pkg;
  localparam int FB_W        = 320;
  localparam int FB_H        = 240;
  localparam int SCALE_SHIFT = 1;
  localparam int FB_SIZE     = FB_W * FB_H;
  localparam int ADDR_W      = 18;
  localparam int CNT_W       = $clog2(FB_SIZE);

  // RRRGGGBB
  typedef logic [7:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_VS = 2'd1,
    CLEAR   = 2'd2
  } state_t;
endpackage

// File: rtl/fb_swap_controller_if.sv
// Signal bundle between the timing generator, draw engine, pixel RAM and the controller.
interface fb_swap_controller_if;
  import fb_pkg::*;

  logic [9:0]        next_x;
  logic [9:0]        next_y;
  logic              vsync;
  logic [ADDR_W-1:0] scan_addr;
  logic              wr_valid;
  logic              wr_ready;
  logic [8:0]        wr_x;
  logic [7:0]        wr_y;
  pixel_t            wr_color;
  logic              swap_req;
  logic              swap_clear;
  pixel_t            clear_color;
  logic              swap_done;
  logic              busy;
  logic              front_sel;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  pixel_t            mem_wdata;

  modport slave (
    input  next_x, next_y, vsync, wr_valid, wr_x, wr_y, wr_color,
           swap_req, swap_clear, clear_color,
    output scan_addr, wr_ready, swap_done, busy, front_sel,
           mem_we, mem_waddr, mem_wdata
  );

  modport master (
    output next_x, next_y, vsync, wr_valid, wr_x, wr_y, wr_color,
           swap_req, swap_clear, clear_color,
    input  scan_addr, wr_ready, swap_done, busy, front_sel,
           mem_we, mem_waddr, mem_wdata
  );
endinterface

// File: rtl/fb_addr_gen.sv
// Combinational linear address: base + y*FB_W + x, with y*320 built as (y<<8)+(y<<6).
module fb_addr_gen
  import fb_pkg::*;
(
  input  logic [ADDR_W-1:0] i_base,
  input  logic [9:0]        i_x,
  input  logic [9:0]        i_y,
  output logic [ADDR_W-1:0] o_addr
);
  logic [ADDR_W-1:0] w_x;
  logic [ADDR_W-1:0] w_y;

  assign w_x    = ADDR_W'(i_x);
  assign w_y    = ADDR_W'(i_y);
  assign o_addr = i_base + (w_y << 8) + (w_y << 6) + w_x;
endmodule

// File: rtl/fb_swap_controller.sv
// Double-buffered framebuffer controller: scanout addressing, back-buffer writes, vsync swaps.
// Optional hardware clear of the new back buffer when built with FB_CLEAR_EN.
module fb_swap_controller
  import fb_pkg::*;
(
  input  logic               i_clock,
  input  logic               i_reset,   // active-low, asynchronous
  fb_swap_controller_if.slave fb_if
);
  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_front_sel;
  logic              r_swap_done;
  logic              r_vs_prev;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_waddr;
  pixel_t            r_mem_wdata;

  logic [ADDR_W-1:0] w_front_base;
  logic [ADDR_W-1:0] w_back_base;
  logic [ADDR_W-1:0] w_wr_addr;
  logic              w_vs_fall;
  logic              w_wr_ready;
  logic              w_busy;
  logic              w_toggle;
  logic              w_wr_fire;
  logic              w_wr_in_range;

  assign w_front_base  = r_front_sel ? ADDR_W'(FB_SIZE) : '0;
  assign w_back_base   = r_front_sel ? '0 : ADDR_W'(FB_SIZE);
  assign w_vs_fall     = r_vs_prev & ~fb_if.vsync;
  assign w_wr_fire     = fb_if.wr_valid & w_wr_ready;
  assign w_wr_in_range = (fb_if.wr_x < 9'(FB_W)) && (fb_if.wr_y < 8'(FB_H));

  fb_addr_gen u_scan_addr (
    .i_base (w_front_base),
    .i_x    (fb_if.next_x >> SCALE_SHIFT),
    .i_y    (fb_if.next_y >> SCALE_SHIFT),
    .o_addr (fb_if.scan_addr)
  );

  fb_addr_gen u_wr_addr (
    .i_base (w_back_base),
    .i_x    ({1'b0, fb_if.wr_x}),
    .i_y    ({2'b0, fb_if.wr_y}),
    .o_addr (w_wr_addr)
  );

`ifdef FB_CLEAR_EN
  logic [CNT_W-1:0] r_clr_cnt;
  logic             r_clr_flag;
  pixel_t           r_clr_color;
  logic             w_clr_last;

  assign w_clr_last = (r_clr_cnt == CNT_W'(FB_SIZE - 1));
`else
  logic w_unused_clear;
  assign w_unused_clear = ^{fb_if.swap_clear, fb_if.clear_color};
`endif

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wr_ready  = 1'b0;
    w_busy      = 1'b0;
    w_toggle    = 1'b0;
    case (r_state)
      IDLE: begin
        w_wr_ready = 1'b1;
        if (fb_if.swap_req) w_state_nxt = WAIT_VS;
      end
      WAIT_VS: begin
        w_busy = 1'b1;
        if (w_vs_fall) begin
          w_toggle = 1'b1;
`ifdef FB_CLEAR_EN
          w_state_nxt = r_clr_flag ? CLEAR : IDLE;
`else
          w_state_nxt = IDLE;
`endif
        end
      end
      CLEAR: begin
        w_busy = 1'b1;
`ifdef FB_CLEAR_EN
        if (w_clr_last) w_state_nxt = IDLE;
`else
        w_state_nxt = IDLE;
`endif
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Registered RAM write port, swap strobe and buffer select
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_vs_prev   <= 1'b1;
      r_front_sel <= 1'b0;
      r_swap_done <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_waddr <= '0;
      r_mem_wdata <= '0;
`ifdef FB_CLEAR_EN
      r_clr_cnt   <= '0;
      r_clr_flag  <= 1'b0;
      r_clr_color <= '0;
`endif
    end else begin
      r_vs_prev   <= fb_if.vsync;
      r_swap_done <= w_toggle;
      r_mem_we    <= 1'b0;
      if (w_toggle) r_front_sel <= ~r_front_sel;
      if (w_wr_fire && w_wr_in_range) begin
        r_mem_we    <= 1'b1;
        r_mem_waddr <= w_wr_addr;
        r_mem_wdata <= fb_if.wr_color;
      end
`ifdef FB_CLEAR_EN
      if (r_state == IDLE && fb_if.swap_req) begin
        r_clr_flag  <= fb_if.swap_clear;
        r_clr_color <= fb_if.clear_color;
      end
      // front_sel has already toggled, so back_base is the buffer just retired
      if (r_state == CLEAR) begin
        r_mem_we    <= 1'b1;
        r_mem_waddr <= w_back_base + ADDR_W'(r_clr_cnt);
        r_mem_wdata <= r_clr_color;
        r_clr_cnt   <= w_clr_last ? '0 : r_clr_cnt + CNT_W'(1);
      end
`endif
    end
  end

  assign fb_if.wr_ready  = w_wr_ready;
  assign fb_if.busy      = w_busy;
  assign fb_if.swap_done = r_swap_done;
  assign fb_if.front_sel = r_front_sel;
  assign fb_if.mem_we    = r_mem_we;
  assign fb_if.mem_waddr = r_mem_waddr;
  assign fb_if.mem_wdata = r_mem_wdata;
endmodule

// File: tb/tb_fb_swap_controller.sv
// Directed bench for fb_swap_controller; clear-path cases are enabled with FB_CLEAR_EN.
module tb_fb_swap_controller;
  import fb_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  fb_swap_controller_if fb_if ();

  fb_swap_controller dut (
    .i_clock (clk),
    .i_reset (rst_n),
    .fb_if   (fb_if)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic req_swap(input logic clr, input pixel_t col);
    fb_if.swap_req    = 1'b1;
    fb_if.swap_clear  = clr;
    fb_if.clear_color = col;
    step();
    fb_if.swap_req    = 1'b0;
    fb_if.swap_clear  = 1'b0;
  endtask

  task automatic vs_fall_step();
    fb_if.vsync = 1'b0;
    step();
    fb_if.vsync = 1'b1;
  endtask

  task automatic write_px(input logic [8:0] x, input logic [7:0] y, input pixel_t c);
    fb_if.wr_valid = 1'b1;
    fb_if.wr_x     = x;
    fb_if.wr_y     = y;
    fb_if.wr_color = c;
    step();
    fb_if.wr_valid = 1'b0;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int bad;
    int bad_busy;
    fb_if.next_x = '0;  fb_if.next_y = '0;  fb_if.vsync = 1'b1;
    fb_if.wr_valid = 1'b0;  fb_if.wr_x = '0;  fb_if.wr_y = '0;  fb_if.wr_color = '0;
    fb_if.swap_req = 1'b0;  fb_if.swap_clear = 1'b0;  fb_if.clear_color = '0;

    // Reset
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    step();
    check("rst_front_sel", fb_if.front_sel, 0);
    check("rst_busy",      fb_if.busy,      0);
    check("rst_wr_ready",  fb_if.wr_ready,  1);
    check("rst_mem_we",    fb_if.mem_we,    0);
    check("rst_swap_done", fb_if.swap_done, 0);
    check("rst_mem_waddr", fb_if.mem_waddr, 0);

    // Scanout address, front buffer 0
    fb_if.next_x = 10'd2;  fb_if.next_y = 10'd2;  #1;
    check("scan_2_2_f0", fb_if.scan_addr, 321);
    fb_if.next_x = 10'd639;  fb_if.next_y = 10'd479;  #1;
    check("scan_max_f0", fb_if.scan_addr, 76799);

    // Draw writes into back buffer 1
    write_px(9'd5, 8'd2, 8'hE0);
    check("wr_we",    fb_if.mem_we,    1);
    check("wr_addr",  fb_if.mem_waddr, 77445);
    check("wr_data",  fb_if.mem_wdata, 8'hE0);
    step();
    check("wr_we_drop", fb_if.mem_we, 0);
    fb_if.wr_valid = 1'b1;  fb_if.wr_x = 9'd320;  fb_if.wr_y = 8'd0;  #1;
    check("oor_x_ready", fb_if.wr_ready, 1);
    step();
    fb_if.wr_valid = 1'b0;
    check("oor_x_we", fb_if.mem_we, 0);
    write_px(9'd0, 8'd240, 8'h11);
    check("oor_y_we", fb_if.mem_we, 0);

    // Swap without clear, vsync falls 1000 cycles later
    req_swap(1'b0, 8'h00);
    fb_if.wr_valid = 1'b1;  fb_if.wr_x = 9'd1;  fb_if.wr_y = 8'd1;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      if (fb_if.busy !== 1'b1 || fb_if.wr_ready !== 1'b0 ||
          fb_if.swap_done !== 1'b0 || fb_if.mem_we !== 1'b0) bad++;
      step();
    end
    fb_if.wr_valid = 1'b0;
    check("wait_vs_hold", bad, 0);
    check("wait_front_sel", fb_if.front_sel, 0);
    vs_fall_step();
    check("swap_front_sel", fb_if.front_sel, 1);
    check("swap_done_hi",   fb_if.swap_done, 1);
    check("swap_idle_rdy",  fb_if.wr_ready,  1);
    check("swap_idle_busy", fb_if.busy,      0);
    step();
    check("swap_done_lo", fb_if.swap_done, 0);
    fb_if.next_x = 10'd2;  fb_if.next_y = 10'd2;  #1;
    check("scan_2_2_f1", fb_if.scan_addr, 77121);

    // vsync fall in IDLE
    vs_fall_step();
    check("idle_vs_front", fb_if.front_sel, 1);
    check("idle_vs_done",  fb_if.swap_done, 0);
    step();

    // Back buffer is now 0; write together with swap request
    write_px(9'd5, 8'd2, 8'h3C);
    check("wr_f1_addr", fb_if.mem_waddr, 645);
    fb_if.swap_req = 1'b1;
    write_px(9'd7, 8'd0, 8'h55);
    fb_if.swap_req = 1'b0;
    check("combo_we",   fb_if.mem_we,    1);
    check("combo_addr", fb_if.mem_waddr, 7);
    check("combo_data", fb_if.mem_wdata, 8'h55);
    check("combo_busy", fb_if.busy,      1);
    vs_fall_step();
    check("combo_front", fb_if.front_sel, 0);
    check("combo_done",  fb_if.swap_done, 1);

    // Swap with clear request
    req_swap(1'b1, 8'h1C);
    check("clr_wait_busy", fb_if.busy, 1);
    vs_fall_step();
    check("clr_front", fb_if.front_sel, 1);
    check("clr_done",  fb_if.swap_done, 1);
    check("clr_we0",   fb_if.mem_we,    0);
`ifdef FB_CLEAR_EN
    bad = 0;
    bad_busy = 0;
    for (int i = 0; i < FB_SIZE; i++) begin
      fb_if.swap_req = (i == 100);
      fb_if.vsync    = (i != 200);
      step();
      if (fb_if.mem_we !== 1'b1 || fb_if.mem_waddr !== ADDR_W'(i) ||
          fb_if.mem_wdata !== 8'h1C) bad++;
      if (i < FB_SIZE - 1 && (fb_if.busy !== 1'b1 || fb_if.wr_ready !== 1'b0)) bad_busy++;
    end
    fb_if.swap_req = 1'b0;
    fb_if.vsync    = 1'b1;
    check("clr_writes", bad, 0);
    check("clr_busy",   bad_busy, 0);
    check("clr_end_rdy", fb_if.wr_ready, 1);
    step();
    check("clr_end_we", fb_if.mem_we, 0);
    vs_fall_step();
    check("clr_ignored_swap_front", fb_if.front_sel, 1);
    check("clr_ignored_swap_done",  fb_if.swap_done, 0);
    step();

    // Reset in the middle of a clear
    req_swap(1'b1, 8'h03);
    vs_fall_step();
    check("clr2_front", fb_if.front_sel, 0);
    repeat (1000) step();
    check("clr2_we",   fb_if.mem_we,    1);
    check("clr2_addr", fb_if.mem_waddr, FB_SIZE + 999);
    rst_n = 1'b0;  #1;
    check("clr2_rst_we",    fb_if.mem_we,    0);
    check("clr2_rst_front", fb_if.front_sel, 0);
    check("clr2_rst_busy",  fb_if.busy,      0);
    check("clr2_rst_addr",  fb_if.mem_waddr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("clr2_no_resume", fb_if.mem_we, 0);
    check("clr2_rdy",       fb_if.wr_ready, 1);
`else
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (fb_if.mem_we !== 1'b0 || fb_if.busy !== 1'b0) bad++;
    end
    check("noclr_no_writes", bad, 0);
`endif

    // Reset while waiting for vsync
    req_swap(1'b0, 8'h00);
    repeat (20) step();
    check("wvs_busy", fb_if.busy, 1);
    rst_n = 1'b0;  #1;
    check("wvs_rst_busy",  fb_if.busy,      0);
    check("wvs_rst_front", fb_if.front_sel, 0);
    check("wvs_rst_rdy",   fb_if.wr_ready,  1);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    vs_fall_step();
    check("wvs_no_resume_front", fb_if.front_sel, 0);
    check("wvs_no_resume_done",  fb_if.swap_done, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fb_swap_controller.md
Name: fb_swap_controller

Overview:
- Framebuffer controller between the VGA timing/colour generator and a dual-port pixel RAM holding two framebuffers (front and back) of 8-bit RRRGGGBB pixels.
- Generates the scanout read address for the front buffer from the timing generator's next_x/next_y.
- Forwards draw-engine writes to the back buffer.
- Performs vsync-synchronised front/back swaps, with an optional hardware clear of the new back buffer.

Parameters:
- FB_W, 320, framebuffer width in stored pixels.
- FB_H, 240, framebuffer height in stored pixels.
- SCALE_SHIFT, 1, display-to-framebuffer downscale (x>>S, y>>S).
- FB_SIZE, 76800, pixels per buffer (FB_W*FB_H).
- ADDR_W, 18, RAM address width (two buffers).

Ports:
- clock  in  1  25 MHz pixel clock.
- reset  in  1  Asynchronous, active-low reset.
- next_x  in  10  Next display x from timing generator.
- next_y  in  10  Next display y from timing generator.
- vsync  in  1  VSYNC from timing generator; active-low pulse.
- scan_addr  out  ADDR_W  Front-buffer read address for the RAM scanout port.
- wr_valid  in  1  Draw write request.
- wr_ready  out  1  Controller accepts a write this cycle.
- wr_x  in  9  Framebuffer x of the write.
- wr_y  in  8  Framebuffer y of the write.
- wr_color  in  8  Pixel data to write.
- swap_req  in  1  Single-cycle request to swap buffers at the next vsync.
- swap_clear  in  1  Sampled with swap_req; clear the new back buffer after the swap.
- clear_color  in  8  Sampled with swap_req; fill value for the clear.
- swap_done  out  1  One-cycle pulse when front_sel toggles.
- busy  out  1  Swap pending or clear in progress.
- front_sel  out  1  Index of the buffer currently scanned out.
- mem_we  out  1  RAM write-port enable.
- mem_waddr  out  ADDR_W  RAM write-port address.
- mem_wdata  out  8  RAM write-port data.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, front_sel=0, swap_done=0, busy=0.
  - mem_we=0, mem_waddr=0, mem_wdata=0.
  - Clear counter=0, vsync history register=1.
- Buffer bases: buffer 0 at 0, buffer 1 at FB_SIZE. back_base is the base of the buffer not selected by front_sel.
- scan_addr (combinational):
  - Formula: front base + (next_y>>S)*FB_W + (next_x>>S).
  - Multiply implemented as shift-add ((y<<8)+(y<<6) for FB_W=320).
  - Scanout-port latency is absorbed outside this block.
- vsync edge:
  - vsync is registered each cycle.
  - vs_fall = registered_prev & ~vsync, evaluated on the sampled value.
- State IDLE:
  - wr_ready=1, busy=0.
  - A write fires when wr_valid & wr_ready.
  - Next cycle: mem_we=1, mem_waddr=back_base+wr_y*FB_W+wr_x, mem_wdata=wr_color. Latency is 1 clock; outputs are registered.
  - Out-of-range write (wr_x>=FB_W or wr_y>=FB_H): handshake completes, mem_we=0.
  - swap_req: latch swap_clear and clear_color, go to WAIT_VS.
  - swap_req together with wr_valid in the same cycle: write is issued, and the swap is latched.
- State WAIT_VS:
  - wr_ready=0, busy=1, mem_we=0.
  - On vs_fall: front_sel toggles on that edge and swap_done pulses for 1 cycle.
  - Next state is CLEAR if the latched clear flag is set, else IDLE.
- State CLEAR:
  - wr_ready=0, busy=1.
  - Each cycle: mem_we=1, mem_waddr=new back_base+cnt, mem_wdata=latched colour.
  - cnt runs 0..FB_SIZE-1, then returns to 0; state goes to IDLE.
  - Exactly FB_SIZE writes are issued.
- swap_req outside IDLE is ignored; no queueing.
- vs_fall in IDLE or CLEAR has no effect.
- Reset mid-CLEAR or mid-WAIT_VS: immediate return to reset values. The partial clear is not resumed.

Optional Feature:
- Macro FB_CLEAR_EN.
- Defined: CLEAR state, clear counter and clear_color latch are present, as above.
- Undefined:
  - No CLEAR state; swap_clear and clear_color are ignored.
  - WAIT_VS always returns to IDLE after the swap.
  - mem_we is driven only by draw writes.

Decomposition:
- Shared package fb_pkg holds:
  - FB_W, FB_H, FB_SIZE, ADDR_W, SCALE_SHIFT constants.
  - The 8-bit pixel type (RRRGGGBB).
  - The state encoding (IDLE=0, WAIT_VS=1, CLEAR=2).
- One natural sub-module: fb_addr_gen. It is a combinational base + y*FB_W + x shift-add, instantiated twice (scanout path and write path).

Test Plan:
- Reset: hold reset=0 mid-stream, release -> front_sel=0, busy=0, wr_ready=1, mem_we=0, swap_done=0.
- Write in IDLE with front_sel=0: wr_x=5, wr_y=2, wr_color=0xE0 -> next cycle mem_we=1, mem_waddr=77445, mem_wdata=0xE0.
- Out-of-range write: wr_x=320, wr_y=0 -> wr_ready=1, mem_we stays 0.
- Swap without clear: swap_req with vsync falling 1000 cycles later:
  - busy=1 and wr_ready=0 throughout the wait.
  - front_sel=1 and a single swap_done pulse.
  - IDLE on the following cycle.
  - Then next_x=2, next_y=2 -> scan_addr=77121.
- Swap with clear (FB_CLEAR_EN defined): swap_clear=1, clear_color=0x1C ->
  - After swap_done, 76800 consecutive writes to addresses 0..76799 with data 0x1C.
  - Then wr_ready=1.
  - With the macro undefined, no writes occur.
- Boundary: swap_req during CLEAR is ignored (front_sel unchanged at next vsync). vsync fall in IDLE changes nothing. Reset asserted at cnt=1000 -> front_sel=0, mem_we=0 immediately.
